rd_pipe_tracker: RTL

RD_PIPE_TRACKER -- requirements
Module: rd_pipe_tracker

---
 rtl/rd_pipe_tracker.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/rd_pipe_tracker.sv
// rd_pipe_tracker: tracks destination/source registers through EX, MEM and WB.
// It produces the load-use hazard signal, the EX operand forwarding selects,
// and the register retiring in WB.
module rd_pipe_tracker #(
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_reg_write,
    input  logic                  id_mem_read,
    input  logic                  stall,
    input  logic                  flush,
    output logic                  load_use_hazard,
    output logic [1:0]            fwd_a,
    output logic [1:0]            fwd_b,
    output logic [REG_ADDR_W-1:0] rd_out,
    output logic                  wb_reg_write
);

    // Common tracking fields of every stage.
    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] rd;
        logic                  reg_write;
        logic                  mem_read;
    } stage_t;

    // EX also keeps its source registers for the forwarding compares.
    typedef struct packed {
        stage_t                base;
        logic [REG_ADDR_W-1:0] rs1;
        logic [REG_ADDR_W-1:0] rs2;
    } ex_stage_t;

    localparam int MEM_IDX = 0;
    localparam int WB_IDX  = 1;

    // Empty (bubble) entry for the common stages.
    function automatic stage_t empty_stage();
        stage_t s;
        s.valid     = 1'b0;
        s.rd        = {REG_ADDR_W{1'b0}};
        s.reg_write = 1'b0;
        s.mem_read  = 1'b0;
        return s;
    endfunction

    // Empty (bubble) entry for EX.
    function automatic ex_stage_t empty_ex();
        ex_stage_t e;
        e.base = empty_stage();
        e.rs1  = {REG_ADDR_W{1'b0}};
        e.rs2  = {REG_ADDR_W{1'b0}};
        return e;
    endfunction

    // True when stage s will write register rs.
    // x0 never counts as a producer.
    function automatic logic produces(input stage_t s, input logic [REG_ADDR_W-1:0] rs);
        return s.valid & s.reg_write & (s.rd != {REG_ADDR_W{1'b0}}) & (s.rd == rs);
    endfunction

    // Operand source select. MEM is the younger producer, so it wins over WB.
    function automatic logic [1:0] fwd_sel(input stage_t mem_s, input stage_t wb_s,
                                           input logic [REG_ADDR_W-1:0] rs);
        logic [1:0] sel;
        if (produces(mem_s, rs)) begin
            sel = 2'b10;
        end else if (produces(wb_s, rs)) begin
            sel = 2'b01;
        end else begin
            sel = 2'b00;
        end
        return sel;
    endfunction

    ex_stage_t ex_r;
    ex_stage_t ex_next_s;
    stage_t    trk_r      [2];
    stage_t    trk_next_s [2];
    ex_stage_t id_entry_s;
    logic      hazard_s;

    // Load-use hazard: a load in EX whose destination is read by the ID instruction.
    always_comb begin
        hazard_s = id_valid & ex_r.base.valid & ex_r.base.mem_read &
                   (ex_r.base.rd != {REG_ADDR_W{1'b0}}) &
                   ((ex_r.base.rd == id_rs1) | (ex_r.base.rd == id_rs2));
    end

    // Assemble the entry that the ID instruction would occupy in EX.
    always_comb begin
        id_entry_s.base.valid     = id_valid;
        id_entry_s.base.rd        = id_rd;
        id_entry_s.base.reg_write = id_reg_write;
        id_entry_s.base.mem_read  = id_mem_read;
        id_entry_s.rs1            = id_rs1;
        id_entry_s.rs2            = id_rs2;
    end

    // Next-state selection.
    // flush beats stall and hazard for EX; stall freezes MEM and WB.
    always_comb begin
        ex_next_s           = ex_r;
        trk_next_s[MEM_IDX] = trk_r[MEM_IDX];
        trk_next_s[WB_IDX]  = trk_r[WB_IDX];
        if (flush) begin
            ex_next_s = empty_ex();
        end else if (stall) begin
            ex_next_s = ex_r;
        end else if (hazard_s) begin
            ex_next_s = empty_ex();
        end else begin
            ex_next_s = id_entry_s;
        end
        if (stall) begin
            trk_next_s[MEM_IDX] = trk_r[MEM_IDX];
            trk_next_s[WB_IDX]  = trk_r[WB_IDX];
        end else begin
            trk_next_s[MEM_IDX] = ex_r.base;
            trk_next_s[WB_IDX]  = trk_r[MEM_IDX];
        end
    end

    // Tracking registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_r           <= empty_ex();
            trk_r[MEM_IDX] <= empty_stage();
            trk_r[WB_IDX]  <= empty_stage();
        end else begin
            ex_r           <= ex_next_s;
            trk_r[MEM_IDX] <= trk_next_s[MEM_IDX];
            trk_r[WB_IDX]  <= trk_next_s[WB_IDX];
        end
    end

    // Output decode from the registered stage contents.
    // Forwarding is suppressed when EX is empty.
    always_comb begin
        load_use_hazard = hazard_s;
        if (ex_r.base.valid) begin
            fwd_a = fwd_sel(trk_r[MEM_IDX], trk_r[WB_IDX], ex_r.rs1);
            fwd_b = fwd_sel(trk_r[MEM_IDX], trk_r[WB_IDX], ex_r.rs2);
        end else begin
            fwd_a = 2'b00;
            fwd_b = 2'b00;
        end
        wb_reg_write = trk_r[WB_IDX].valid & trk_r[WB_IDX].reg_write;
        if (trk_r[WB_IDX].valid & trk_r[WB_IDX].reg_write) begin
            rd_out = trk_r[WB_IDX].rd;
        end else begin
            rd_out = {REG_ADDR_W{1'b0}};
        end
    end

endmodule
